config_regs_arbiter: RTL and testbench

Round-robin OBI arbiter that lets `NUM_REQ` masters share the single slave port of the cache controller's configuration register block. Examples of masters are the host bus bridge and the debug/bring-up port. It forwards one request at a time to the register slave and tracks the owner of the outstanding transaction. It routes the response back only to that owner. A watchdog terminates transactions whose response never arrives.

---
 rtl/config_regs_arbiter.sv | 114 +++++++++++
 tb/tb_config_regs_arbiter.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/config_regs_arbiter.sv
// rtl/config_regs_arbiter.sv - round-robin OBI arbiter in front of the config register slave
// Forwards one request at a time, routes the response to its owner, and watchdogs lost responses.
module config_regs_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [NUM_REQ-1:0]      s_req_i,
  input  logic [NUM_REQ-1:0]      s_we_i,
  input  logic [NUM_REQ*4-1:0]    s_be_i,
  input  logic [NUM_REQ*32-1:0]   s_addr_i,
  input  logic [NUM_REQ*32-1:0]   s_wdata_i,
  output logic [NUM_REQ-1:0]      s_gnt_o,
  output logic [NUM_REQ-1:0]      s_rvalid_o,
  output logic [31:0]             s_rdata_o,
  output logic                    m_req_o,
  output logic                    m_we_o,
  output logic [3:0]              m_be_o,
  output logic [31:0]             m_addr_o,
  output logic [31:0]             m_wdata_o,
  input  logic                    m_gnt_i,
  input  logic                    m_rvalid_i,
  input  logic [31:0]             m_rdata_i,
  output logic                    timeout_o
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [0:0] IDLE     = 1'b0;
  localparam logic [0:0] WAIT_RSP = 1'b1;

  logic [0:0]    state_q;
  logic [PW-1:0] ptr_q;
  logic [PW-1:0] owner_q;
  logic [CW-1:0] cnt_q;
  logic          timeout_q;

  logic [PW-1:0] win_idx;
  logic [PW-1:0] cand;
  logic          win_valid;
  int            scan;

  // Scan from the highest offset down so the last hit is the first index at or after ptr.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    cand      = '0;
    scan      = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      scan = int'(ptr_q) + k;
      if (scan >= NUM_REQ) scan = scan - NUM_REQ;
      cand = scan[PW-1:0];
      if (s_req_i[cand]) begin
        win_valid = 1'b1;
        win_idx   = cand;
      end
    end
  end

  logic active_idle;
  logic active_wait;
  logic fwd;
  logic hs;
  logic rsp_ok;
  logic expire;

  // Outputs are gated by rst_ni so nothing leaks through while reset is held.
  assign active_idle = rst_ni && (state_q == IDLE);
  assign active_wait = rst_ni && (state_q == WAIT_RSP);
  assign fwd         = active_idle && win_valid;
  assign hs          = fwd && m_gnt_i;
  assign rsp_ok      = active_wait && m_rvalid_i;
  // cnt_q counts completed wait cycles; it would reach TIMEOUT_CYCLES at the end of this cycle.
  assign expire      = active_wait && !m_rvalid_i && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  assign m_req_o   = fwd;
  assign m_we_o    = fwd && s_we_i[win_idx];
  assign m_be_o    = fwd ? s_be_i[{win_idx, 2'b00} +: 4] : 4'h0;
  assign m_addr_o  = fwd ? s_addr_i[{win_idx, 5'b00000} +: 32] : 32'h0;
  assign m_wdata_o = fwd ? s_wdata_i[{win_idx, 5'b00000} +: 32] : 32'h0;

  assign s_gnt_o    = hs ? (NUM_REQ'(1) << win_idx) : '0;
  assign s_rvalid_o = (rsp_ok || expire) ? (NUM_REQ'(1) << owner_q) : '0;
  assign s_rdata_o  = rsp_ok ? m_rdata_i : 32'h0;
  assign timeout_o  = timeout_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      owner_q   <= '0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else if (state_q == IDLE) begin
      cnt_q <= '0;
      if (hs) begin
        state_q <= WAIT_RSP;
        owner_q <= win_idx;
        ptr_q   <= (win_idx == PW'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
      end
    end else begin
      if (rsp_ok || expire) begin
        state_q <= IDLE;
        cnt_q   <= '0;
        if (expire) timeout_q <= 1'b1;
      end else if (cnt_q != CW'(TIMEOUT_CYCLES)) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_config_regs_arbiter.sv
// tb/tb_config_regs_arbiter.sv - self-checking bench for config_regs_arbiter
// Reference model tracks busy/owner/pointer/elapsed-cycles and predicts every output.
module tb_config_regs_arbiter;
  localparam int N  = 2;
  localparam int TO = 16;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic [1:0]  s_req = '0, s_we = '0;
  logic [7:0]  s_be = '0;
  logic [63:0] s_addr = '0, s_wdata = '0;
  logic        m_gnt = 1'b0, m_rvalid = 1'b0;
  logic [31:0] m_rdata = '0;
  logic [1:0]  s_gnt, s_rvalid;
  logic [31:0] s_rdata, m_addr, m_wdata;
  logic        m_req, m_we, tmo;
  logic [3:0]  m_be;

  config_regs_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .s_req_i(s_req), .s_we_i(s_we), .s_be_i(s_be), .s_addr_i(s_addr), .s_wdata_i(s_wdata),
    .s_gnt_o(s_gnt), .s_rvalid_o(s_rvalid), .s_rdata_o(s_rdata),
    .m_req_o(m_req), .m_we_o(m_we), .m_be_o(m_be), .m_addr_o(m_addr), .m_wdata_o(m_wdata),
    .m_gnt_i(m_gnt), .m_rvalid_i(m_rvalid), .m_rdata_i(m_rdata), .timeout_o(tmo)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;

  int   m_busy, m_owner, m_wait, m_ptr, e_win;
  logic m_tmo, e_found;
  logic [106:0] e_all;
  wire  [106:0] obs = {m_req, m_we, m_be, m_addr, m_wdata, s_gnt, s_rvalid, s_rdata, tmo};

  function automatic logic bit_of(input logic [1:0] v, input int i);
    logic [1:0] t;
    t = v >> i;
    return t[0];
  endfunction

  function automatic logic [3:0] be_of(input logic [7:0] v, input int i);
    logic [7:0] t;
    t = v >> (4 * i);
    return t[3:0];
  endfunction

  function automatic logic [31:0] w_of(input logic [63:0] v, input int i);
    logic [63:0] t;
    t = v >> (32 * i);
    return t[31:0];
  endfunction

  task automatic set_m(input int i, input logic we, input logic [3:0] be,
                       input logic [31:0] addr, input logic [31:0] wdata);
    s_we    = (s_we & ~(2'b01 << i)) | (2'(we) << i);
    s_be    = (s_be & ~(8'hF << (4 * i))) | (8'(be) << (4 * i));
    s_addr  = (s_addr & ~(64'hFFFF_FFFF << (32 * i))) | (64'(addr) << (32 * i));
    s_wdata = (s_wdata & ~(64'hFFFF_FFFF << (32 * i))) | (64'(wdata) << (32 * i));
  endtask

  task automatic rand_master(input int i);
    set_m(i, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom & 32'hFFFF_FFFC, $urandom);
  endtask

  task automatic model_reset();
    m_busy = 0; m_owner = 0; m_wait = 0; m_ptr = 0; m_tmo = 1'b0;
  endtask

  task automatic model_eval();
    logic eq, ewe;
    logic [3:0] ebe;
    logic [31:0] ea, ew, erd;
    logic [1:0] eg, erv;
    e_found = 1'b0; e_win = 0;
    for (int k = N - 1; k >= 0; k--)
      if (bit_of(s_req, (m_ptr + k) % N)) begin e_found = 1'b1; e_win = (m_ptr + k) % N; end
    eq = 0; ewe = 0; ebe = 0; ea = 0; ew = 0; erd = 0; eg = 0; erv = 0;
    if (rst_ni && m_busy == 0) begin
      if (e_found) begin
        eq = 1; ewe = bit_of(s_we, e_win); ebe = be_of(s_be, e_win);
        ea = w_of(s_addr, e_win); ew = w_of(s_wdata, e_win);
        if (m_gnt) eg = 2'b01 << e_win;
      end
    end else if (rst_ni) begin
      if (m_rvalid || m_wait == TO) erv = 2'b01 << m_owner;
      if (m_rvalid) erd = m_rdata;
    end
    e_all = {eq, ewe, ebe, ea, ew, eg, erv, erd, m_tmo};
  endtask

  task automatic tick();
    @(posedge clk_i);
    model_eval();
    if (rst_ni) begin
      if (m_busy == 0) begin
        if (e_found && m_gnt) begin
          m_busy = 1; m_owner = e_win; m_ptr = (e_win + 1) % N; m_wait = 1;
        end
      end else if (m_rvalid || m_wait == TO) begin
        m_busy = 0;
        if (!m_rvalid) m_tmo = 1'b1;
      end else begin
        m_wait++;
      end
    end
    #1;
  endtask

  task automatic clear_inputs();
    s_req = '0; s_we = '0; s_be = '0; s_addr = '0; s_wdata = '0;
    m_gnt = 1'b0; m_rvalid = 1'b0; m_rdata = '0;
  endtask

  task automatic apply_reset();
    rst_ni = 1'b0;
    clear_inputs();
    model_reset();
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1'b1;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    model_reset();
    s_req = 2'b11; s_be = 8'hFF; s_addr = {32'h40, 32'h20}; m_gnt = 1'b1;
    m_rvalid = 1'b1; m_rdata = 32'hCAFE_F00D;
    #2;
    n_checks++;
    if (obs !== '0) begin n_fail++; $display("FAIL reset_outputs got=%h exp=0", obs); end
    n_checks++;
    if (dut.ptr_q !== 1'b0 || tmo !== 1'b0) begin
      n_fail++; $display("FAIL reset_state ptr=%b tmo=%b exp 0/0", dut.ptr_q, tmo);
    end
    apply_reset();
  endtask

  task automatic test_single_read();
    s_req = 2'b01; set_m(0, 1'b0, 4'hF, 32'h0, 32'h0); m_gnt = 1'b1;
    #2 model_eval();
    n_checks++;
    if (s_gnt !== 2'b01 || m_addr !== 32'h0 || obs !== e_all) begin
      n_fail++; $display("FAIL single_grant gnt=%b got=%h exp=%h", s_gnt, obs, e_all);
    end
    tick();
    s_req = 2'b00; m_gnt = 1'b0; m_rvalid = 1'b1; m_rdata = 32'h1;
    #2;
    n_checks++;
    if (s_rvalid !== 2'b01 || s_rdata !== 32'h1 || m_req !== 1'b0) begin
      n_fail++; $display("FAIL single_rsp rvalid=%b rdata=%h req=%b exp 01/1/0", s_rvalid, s_rdata, m_req);
    end
    tick();
    m_rvalid = 1'b0;
    n_checks++;
    if (dut.ptr_q !== 1'b1) begin n_fail++; $display("FAIL single_ptr got=%b exp=1", dut.ptr_q); end
  endtask

  task automatic test_simultaneous();
    apply_reset();
    s_req = 2'b11;
    set_m(0, 1'b0, 4'hF, 32'h10, 32'h0);
    set_m(1, 1'b1, 4'b0001, 32'h20, 32'h1);
    m_gnt = 1'b1;
    for (int c = 0; c < 4; c++) begin
      m_rvalid = c[0];
      m_rdata  = 32'hA500 + c;
      #2 model_eval();
      n_checks++;
      if (obs !== e_all) begin n_fail++; $display("FAIL simul_model cyc=%0d got=%h exp=%h", c, obs, e_all); end
      n_checks++;
      case (c)
        0: if (s_gnt !== 2'b01 || m_addr !== 32'h10) begin
             n_fail++; $display("FAIL simul_first gnt=%b addr=%h exp 01/10", s_gnt, m_addr); end
        1: if (s_rvalid !== 2'b01 || s_rdata !== 32'hA501) begin
             n_fail++; $display("FAIL simul_rsp0 rvalid=%b rdata=%h exp 01/a501", s_rvalid, s_rdata); end
        2: if (s_gnt !== 2'b10 || m_be !== 4'b0001 || m_wdata !== 32'h1 || m_we !== 1'b1) begin
             n_fail++; $display("FAIL simul_second gnt=%b be=%b wdata=%h we=%b exp 10/0001/1/1",
                                s_gnt, m_be, m_wdata, m_we); end
        default: if (s_rvalid !== 2'b10 || s_rdata !== 32'hA503) begin
             n_fail++; $display("FAIL simul_rsp1 rvalid=%b rdata=%h exp 10/a503", s_rvalid, s_rdata); end
      endcase
      tick();
      if (c == 0) s_req = 2'b10;
      if (c == 2) s_req = 2'b00;
    end
    m_rvalid = 1'b0; m_gnt = 1'b0;
  endtask

  task automatic test_fairness();
    int sl = 0, prev = -1, ngr = 0, cyc = 0, gi;
    logic hs;
    rand_master(0); rand_master(1);
    s_req = 2'b11;
    while (ngr < 8 && cyc < 200) begin
      m_gnt    = ($urandom_range(0, 3) != 0);
      m_rvalid = (sl == 1) || (m_busy == 0 && sl == 0 && $urandom_range(0, 7) == 0);
      m_rdata  = $urandom;
      #2 model_eval();
      n_checks++;
      if (obs !== e_all) begin n_fail++; $display("FAIL fair_model cyc=%0d got=%h exp=%h", cyc, obs, e_all); end
      hs = m_req & m_gnt;
      gi = -1;
      if (s_gnt !== 2'b00) begin
        gi = (s_gnt == 2'b10) ? 1 : 0;
        n_checks++;
        if (gi == prev) begin n_fail++; $display("FAIL fair_alternate got=%0d exp=%0d", gi, 1 - prev); end
        prev = gi; ngr++;
      end
      tick();
      if (sl > 0) sl--;
      if (hs) sl = $urandom_range(1, 3);
      if (gi >= 0) rand_master(gi);
      cyc++;
    end
    n_checks++;
    if (ngr < 8) begin n_fail++; $display("FAIL fair_budget grants=%0d exp=8", ngr); end
    while (m_busy != 0 && cyc < 220) begin
      s_req = 2'b00; m_gnt = 1'b0; m_rvalid = (sl == 1);
      tick();
      if (sl > 0) sl--;
      cyc++;
    end
    clear_inputs();
  endtask

  task automatic test_timeout();
    for (int pass = 0; pass < 2; pass++) begin
      s_req = (pass == 0) ? 2'b01 : 2'b10;
      set_m(pass, 1'b0, 4'hF, 32'h100, 32'h0);
      m_gnt = 1'b1;
      #2 model_eval();
      n_checks++;
      if (s_gnt !== s_req || obs !== e_all) begin
        n_fail++; $display("FAIL tmo_grant pass=%0d gnt=%b got=%h exp=%h", pass, s_gnt, obs, e_all);
      end
      tick();
      s_req = 2'b00; m_gnt = 1'b0;
      for (int c = 1; c <= TO; c++) begin
        m_rvalid = (pass == 0 && c == TO);
        m_rdata  = 32'h5A5A_0000 + c;
        #2 model_eval();
        n_checks++;
        if (obs !== e_all) begin n_fail++; $display("FAIL tmo_model pass=%0d cyc=%0d got=%h exp=%h", pass, c, obs, e_all); end
        n_checks++;
        if (c < TO && s_rvalid !== 2'b00) begin
          n_fail++; $display("FAIL tmo_early pass=%0d cyc=%0d rvalid=%b exp 00", pass, c, s_rvalid);
        end else if (c == TO && pass == 0 && (s_rvalid !== 2'b01 || s_rdata !== 32'h5A5A_0010)) begin
          n_fail++; $display("FAIL tmo_edge_rsp rvalid=%b rdata=%h exp 01/5a5a0010", s_rvalid, s_rdata);
        end else if (c == TO && pass == 1 && (s_rvalid !== 2'b10 || s_rdata !== 32'h0)) begin
          n_fail++; $display("FAIL tmo_expire rvalid=%b rdata=%h exp 10/0", s_rvalid, s_rdata);
        end
        tick();
      end
      m_rvalid = 1'b0;
      n_checks++;
      if (tmo !== (pass == 1)) begin n_fail++; $display("FAIL tmo_flag pass=%0d got=%b exp=%0d", pass, tmo, pass); end
    end
    for (int c = 0; c < 3; c++) begin
      m_rvalid = 1'b1; m_rdata = 32'hDEAD_BEEF;
      #2;
      n_checks++;
      if (s_rvalid !== 2'b00 || s_rdata !== 32'h0 || tmo !== 1'b1) begin
        n_fail++; $display("FAIL tmo_late rvalid=%b rdata=%h tmo=%b exp 00/0/1", s_rvalid, s_rdata, tmo);
      end
      tick();
    end
    m_rvalid = 1'b0;
  endtask

  task automatic test_reset_mid();
    s_req = 2'b01; set_m(0, 1'b1, 4'hF, 32'h8, 32'h77); m_gnt = 1'b1;
    tick();
    n_checks++;
    if (dut.ptr_q !== 1'(m_ptr) || m_busy != 1) begin
      n_fail++; $display("FAIL rmid_setup ptr=%b exp=%0d", dut.ptr_q, m_ptr);
    end
    rst_ni = 1'b0; s_req = 2'b11; m_rvalid = 1'b1; m_rdata = 32'h1234_5678;
    model_reset();
    #1;
    for (int c = 0; c < 3; c++) begin
      n_checks++;
      if (obs !== '0) begin n_fail++; $display("FAIL rmid_outputs cyc=%0d got=%h exp=0", c, obs); end
      @(posedge clk_i); #1;
    end
    rst_ni = 1'b1; s_req = 2'b00; m_gnt = 1'b0;
    #2 model_eval();
    n_checks++;
    if (s_rvalid !== 2'b00 || s_rdata !== 32'h0 || dut.ptr_q !== 1'b0 || tmo !== 1'b0 || obs !== e_all) begin
      n_fail++; $display("FAIL rmid_release rvalid=%b rdata=%h ptr=%b tmo=%b exp 00/0/0/0",
                         s_rvalid, s_rdata, dut.ptr_q, tmo);
    end
    tick();
    m_rvalid = 1'b0;
  endtask

  task automatic test_idle();
    s_req = 2'b01; set_m(0, 1'b0, 4'hF, 32'h0, 32'h0); m_gnt = 1'b1;
    tick();
    s_req = 2'b00; m_gnt = 1'b0; m_rvalid = 1'b1; m_rdata = 32'h9;
    tick();
    m_rvalid = 1'b0;
    for (int c = 0; c < 10; c++) begin
      m_gnt = 1'($urandom_range(0, 1));
      #2;
      n_checks++;
      if (m_req !== 1'b0 || s_gnt !== 2'b00 || dut.ptr_q !== 1'(m_ptr)) begin
        n_fail++; $display("FAIL idle_bus cyc=%0d req=%b gnt=%b ptr=%b exp 0/00/%0d", c, m_req, s_gnt, dut.ptr_q, m_ptr);
      end
      tick();
    end
    n_checks++;
    if (dut.ptr_q !== 1'b1) begin n_fail++; $display("FAIL idle_ptr got=%b exp=1", dut.ptr_q); end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1);
  end

  initial begin
    model_reset();
    #1;
    test_reset();
    test_single_read();
    test_simultaneous();
    test_fairness();
    test_timeout();
    test_reset_mid();
    test_idle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
